gray_seq_ctrl: RTL

Command-driven sequencer for the Gray code counter datapath. It decides when the counter steps, in which direction, at what rate (prescaler) and when it stops (free-run or one-shot to a limit). It sits between the top-level pin mapping (ui_in controls, uo_out Gray value) and an instantiated counting core. It reports busy, done and wrap status.

---
 rtl/gray_pkg.sv | 19 +
 rtl/gray_count_core.sv | 47 ++++
 rtl/gray_seq_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, defaults and Gray conversion for the Gray counter sequencer
package gray_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Generic up to 32 bits; callers cast the result down to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_core.sv
// rtl/gray_count_core.sv - binary up/down counter with a registered Gray image and wrap event
module gray_count_core
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             up,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             wrap_evt
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;

  always_comb begin
    bin_d = bin_q;
    if (load) begin
      bin_d = load_val;
    end else if (step) begin
      bin_d = up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
    end
    // Gray is derived from the next binary so both registers update on the same edge.
    gray_d = WIDTH'(bin2gray(32'(bin_d)));
  end

  assign wrap_evt = step && !load && (up ? (&bin_q) : (bin_q == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign binary = bin_q;
  assign gray   = gray_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - command sequencer: FSM, prescaler and start-time configuration latches
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               dir,
  input  logic               one_shot,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   limit,
  output logic [WIDTH-1:0]   gray,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic               dir_q, dir_d;
  logic               os_q, os_d;
  logic               busy_q, done_q, wrap_q;

  logic               load, step, wrap_evt;
  logic [WIDTH-1:0]   load_val, binary, target, next_bin;

  gray_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .up       (dir_q),
    .binary   (binary),
    .gray     (gray),
    .wrap_evt (wrap_evt)
  );

  assign load_val = dir ? '0 : limit;
  assign target   = dir_q ? limit_q : '0;
  assign next_bin = dir_q ? (binary + WIDTH'(1)) : (binary - WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    os_d    = os_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause && start) begin
          dir_d   = dir;
          os_d    = one_shot;
          presc_d = presc;
          limit_d = limit;
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (os_q && (binary == target)) begin
          // Loaded value already sits on the target: finish without stepping.
          state_d = ST_DONE;
        end else if (cnt_q == presc_q) begin
          step  = 1'b1;
          cnt_d = '0;
          if (os_q && (next_bin == target)) begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + PRESC_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      os_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      os_q    <= os_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSE);
      done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
      wrap_q  <= wrap_evt && !os_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule
